// File: rtl/cv32e40x_instr_aligner_pkg.sv
// Shared types and helpers for the instruction aligner.
//   aligner_entry_t   : one buffered fetch word with its bus error flag
//   ALIGNER_DEPTH_MAX : largest supported buffer depth
//   ALIGNER_CNT_W     : width of the occupancy counter (holds 0..ALIGNER_DEPTH_MAX)
//   is_compressed()   : true when a halfword starts a 16-bit instruction
package cv32e40x_instr_aligner_pkg;

  localparam int ALIGNER_DEPTH_MAX = 8;
  localparam int ALIGNER_CNT_W     = $clog2(ALIGNER_DEPTH_MAX + 1);

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } aligner_entry_t;

  function automatic logic is_compressed(input logic [15:0] hword);
    return hword[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/cv32e40x_aligner_fifo.sv
// Circular word buffer for the instruction aligner.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   flush        : drop all entries (wins over push and pop)
//   push         : write push_data at the tail (ignored when full)
//   push_data    : word and error flag to store
//   pop          : release the head entry (ignored when empty)
//   head_entry   : entry at the read pointer
//   next_entry   : entry following the head (wraps), used for straddles
//   count        : number of valid entries, 0..DEPTH
// DEPTH legal range is 2..ALIGNER_DEPTH_MAX.
module cv32e40x_aligner_fifo
  import cv32e40x_instr_aligner_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  aligner_entry_t           push_data,
  input  logic                     pop,
  output aligner_entry_t           head_entry,
  output aligner_entry_t           next_entry,
  output logic [ALIGNER_CNT_W-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  aligner_entry_t           mem_q [DEPTH];
  logic [PW-1:0]            rd_ptr_q;
  logic [PW-1:0]            wr_ptr_q;
  logic [ALIGNER_CNT_W-1:0] count_q;
  logic                     push_en;
  logic                     pop_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push_en = push && !flush && (count_q < ALIGNER_CNT_W'(DEPTH));
  assign pop_en  = pop && !flush && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_en) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + ALIGNER_CNT_W'(1);
        2'b01:   count_q <= count_q - ALIGNER_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign next_entry = mem_q[ptr_inc(rd_ptr_q)];
  assign count      = count_q;

endmodule

// File: rtl/cv32e40x_instr_aligner.sv
// Instruction aligner: buffers word-aligned fetch responses and presents one
// naturally aligned 16- or 32-bit instruction per handshake, with its PC and
// the OR of the bus errors of the words it occupies.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   fetch_valid_i/ready : fetch response handshake; ready depends on the
//                         registered occupancy only
//   fetch_rdata_i/err_i : fetched word and its bus error
//   branch_i/addr_i     : flush and redirect to a halfword-aligned target
//   instr_valid_o/ready : instruction handshake towards the IF/ID register
//   instr_rdata_o       : instruction, compressed ones zero-extended
//   instr_pc_o          : PC of the presented instruction
//   instr_compressed_o  : presented instruction is 16-bit
//   instr_err_o         : bus error on any word the instruction occupies
// Build option CV32E40X_ALIGNER_BYPASS_EN: when defined, an instruction can be
// formed directly from the incoming fetch word in the cycle it arrives.
module cv32e40x_instr_aligner
  import cv32e40x_instr_aligner_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_compressed_o,
  output logic        instr_err_o
);

  logic                     hw_q;
  logic [31:1]              pc_q;
  aligner_entry_t           head_entry;
  aligner_entry_t           next_entry;
  aligner_entry_t           push_data;
  logic [ALIGNER_CNT_W-1:0] count;
  logic [15:0]              h0;
  logic                     dec_valid;
  logic [31:0]              dec_rdata;
  logic                     dec_comp;
  logic                     dec_err;
  logic                     dec_release;
  logic                     fetch_consumed;
  logic                     pop;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     unused_addr_lsb;

  assign unused_addr_lsb = branch_addr_i[0];

  assign push_data = '{rdata: fetch_rdata_i, err: fetch_err_i};

  cv32e40x_aligner_fifo #(
    .DEPTH (DEPTH)
  ) fifo_i (
    .clk        (clk),
    .rst        (rst),
    .flush      (branch_i),
    .push       (fifo_push),
    .push_data  (push_data),
    .pop        (fifo_pop),
    .head_entry (head_entry),
    .next_entry (next_entry),
    .count      (count)
  );

  assign h0 = hw_q ? head_entry.rdata[31:16] : head_entry.rdata[15:0];

`ifdef CV32E40X_ALIGNER_BYPASS_EN
  logic [15:0] fh0;
  assign fh0 = hw_q ? fetch_rdata_i[31:16] : fetch_rdata_i[15:0];
`endif

  // dec_release: the head entry is finished once this instruction pops.
  // fetch_consumed: the incoming word is fully used by a bypassed pop and
  // must not be written into the buffer.
  always_comb begin
    dec_valid      = 1'b0;
    dec_rdata      = '0;
    dec_comp       = 1'b0;
    dec_err        = 1'b0;
    dec_release    = 1'b0;
    fetch_consumed = 1'b0;
    if (count != '0) begin
      if (is_compressed(h0)) begin
        dec_valid   = 1'b1;
        dec_rdata   = {16'h0000, h0};
        dec_comp    = 1'b1;
        dec_err     = head_entry.err;
        dec_release = hw_q;
      end else if (!hw_q) begin
        dec_valid   = 1'b1;
        dec_rdata   = head_entry.rdata;
        dec_err     = head_entry.err;
        dec_release = 1'b1;
      end else if (count >= ALIGNER_CNT_W'(2)) begin
        dec_valid   = 1'b1;
        dec_rdata   = {next_entry.rdata[15:0], h0};
        dec_err     = head_entry.err | next_entry.err;
        dec_release = 1'b1;
`ifdef CV32E40X_ALIGNER_BYPASS_EN
      end else if (fetch_valid_i) begin
        // Second half arrives now; the fetched word is stored afterwards so
        // its upper half becomes the new head.
        dec_valid   = 1'b1;
        dec_rdata   = {fetch_rdata_i[15:0], h0};
        dec_err     = head_entry.err | fetch_err_i;
        dec_release = 1'b1;
`endif
      end else if (head_entry.err) begin
        // Faulting first half: the second half will never be executed, so
        // present it with the error and a zero upper half.
        dec_valid   = 1'b1;
        dec_rdata   = {16'h0000, h0};
        dec_err     = 1'b1;
        dec_release = 1'b1;
      end
    end
`ifdef CV32E40X_ALIGNER_BYPASS_EN
    else if (fetch_valid_i) begin
      if (is_compressed(fh0)) begin
        dec_valid      = 1'b1;
        dec_rdata      = {16'h0000, fh0};
        dec_comp       = 1'b1;
        dec_err        = fetch_err_i;
        fetch_consumed = hw_q;
      end else if (!hw_q) begin
        dec_valid      = 1'b1;
        dec_rdata      = fetch_rdata_i;
        dec_err        = fetch_err_i;
        fetch_consumed = 1'b1;
      end else if (fetch_err_i) begin
        dec_valid      = 1'b1;
        dec_rdata      = {16'h0000, fh0};
        dec_err        = 1'b1;
        fetch_consumed = 1'b1;
      end
    end
`endif
  end

  assign fetch_ready_o      = count < ALIGNER_CNT_W'(DEPTH);
  assign instr_valid_o      = dec_valid && !branch_i;
  assign instr_rdata_o      = instr_valid_o ? dec_rdata : '0;
  assign instr_compressed_o = instr_valid_o && dec_comp;
  assign instr_err_o        = instr_valid_o && dec_err;
  assign instr_pc_o         = {pc_q, 1'b0};

  assign pop       = instr_valid_o && instr_ready_i;
  assign fifo_pop  = pop && dec_release;
  assign fifo_push = fetch_valid_i && fetch_ready_o && !(pop && fetch_consumed);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_q <= 1'b0;
      pc_q <= '0;
    end else if (branch_i) begin
      hw_q <= branch_addr_i[1];
      pc_q <= branch_addr_i[31:1];
    end else if (pop) begin
      pc_q <= pc_q + (dec_comp ? 31'd1 : 31'd2);
      if (dec_comp) begin
        hw_q <= ~hw_q;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_instr_aligner.sv
module tb_cv32e40x_instr_aligner;

  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i;
  logic        fetch_err_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;
  logic        instr_err_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        comp;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  cv32e40x_instr_aligner #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_ready_o      (fetch_ready_o),
    .fetch_rdata_i      (fetch_rdata_i),
    .fetch_err_i        (fetch_err_i),
    .branch_i           (branch_i),
    .branch_addr_i      (branch_addr_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .instr_rdata_o      (instr_rdata_o),
    .instr_pc_o         (instr_pc_o),
    .instr_compressed_o (instr_compressed_o),
    .instr_err_o        (instr_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_instr(input logic [31:0] pc, input logic [31:0] rdata,
                              input logic comp, input logic err);
    exp_t e;
    e.pc = pc; e.rdata = rdata; e.comp = comp; e.err = err;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted instruction is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && instr_valid_o && instr_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc %h rdata %h expected none", instr_pc_o, instr_rdata_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("instr_pc", instr_pc_o, e.pc);
        check("instr_rdata", instr_rdata_o, e.rdata);
        check("instr_compressed", {31'h0, instr_compressed_o}, {31'h0, e.comp});
        check("instr_err", {31'h0, instr_err_o}, {31'h0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_branch(input logic [31:0] addr);
    branch_i      = 1'b1;
    branch_addr_i = addr;
    #1;
    check("valid_in_branch_cycle", {31'h0, instr_valid_o}, 32'h0);
    tick();
    branch_i = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input logic err);
    fetch_valid_i = 1'b1;
    fetch_rdata_i = w;
    fetch_err_i   = err;
    tick();
    fetch_valid_i = 1'b0;
    fetch_err_i   = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    fetch_valid_i = 1'b0;
    fetch_rdata_i = '0;
    fetch_err_i   = 1'b0;
    branch_i      = 1'b0;
    branch_addr_i = '0;
    instr_ready_i = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_fetch_ready", {31'h0, fetch_ready_o}, 32'h1);
    check("rst_instr_valid", {31'h0, instr_valid_o}, 32'h0);
    check("rst_instr_rdata", instr_rdata_o, 32'h0);
    check("rst_instr_pc", instr_pc_o, 32'h0);
    check("rst_instr_compressed", {31'h0, instr_compressed_o}, 32'h0);
    check("rst_instr_err", {31'h0, instr_err_o}, 32'h0);
    rst = 1'b0;
    tick();

    // Aligned 32-bit followed by two compressed in one word
    instr_ready_i = 1'b1;
    do_branch(32'h0000_0100);
    expect_instr(32'h100, 32'h00A0_0513, 1'b0, 1'b0);
    expect_instr(32'h104, 32'h0000_4581, 1'b1, 1'b0);
    expect_instr(32'h106, 32'h0000_4501, 1'b1, 1'b0);
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h00A0_0513;
    #1;
    check("no_same_cycle_valid", {31'h0, instr_valid_o}, 32'h0);
    tick();
    fetch_rdata_i = 32'h4501_4581;
    check("latency_valid", {31'h0, instr_valid_o}, 32'h1);
    check("latency_pc", instr_pc_o, 32'h100);
    tick();
    fetch_valid_i = 1'b0;
    drain("drain_seq", 10);

    // Straddle from upper half at 0x202, then compressed at 0x206
    do_branch(32'h0000_0202);
    expect_instr(32'h202, 32'h00A0_0513, 1'b0, 1'b0);
    expect_instr(32'h206, 32'h0000_0001, 1'b1, 1'b0);
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h0513_1234;
    tick();
    fetch_rdata_i = 32'h0001_00A0;
    check("straddle_wait_valid", {31'h0, instr_valid_o}, 32'h0);
    tick();
    fetch_valid_i = 1'b0;
    check("straddle_valid", {31'h0, instr_valid_o}, 32'h1);
    drain("drain_straddle", 10);

    // Fill to DEPTH with the consumer stalled
    instr_ready_i = 1'b0;
    do_branch(32'h0000_0300);
    push_word(32'h1111_1113, 1'b0);
    push_word(32'h2222_2223, 1'b0);
    check("ready_before_full", {31'h0, fetch_ready_o}, 32'h1);
    push_word(32'h3333_3333, 1'b0);
    check("full_ready_low", {31'h0, fetch_ready_o}, 32'h0);
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h4444_4443;
    tick();
    tick();
    check("full_still_blocked", {31'h0, fetch_ready_o}, 32'h0);
    check("full_head_valid", {31'h0, instr_valid_o}, 32'h1);
    check("full_head_rdata", instr_rdata_o, 32'h1111_1113);
    fetch_valid_i = 1'b0;
    expect_instr(32'h300, 32'h1111_1113, 1'b0, 1'b0);
    expect_instr(32'h304, 32'h2222_2223, 1'b0, 1'b0);
    expect_instr(32'h308, 32'h3333_3333, 1'b0, 1'b0);
    instr_ready_i = 1'b1;
    #1;
    check("pop_no_same_cycle_ready", {31'h0, fetch_ready_o}, 32'h0);
    tick();
    check("ready_after_pop", {31'h0, fetch_ready_o}, 32'h1);
    drain("drain_full", 10);

    // Error propagation: compressed at 0x0 ignores next word's error
    instr_ready_i = 1'b0;
    do_branch(32'h0000_0000);
    push_word(32'h0513_4581, 1'b0);
    push_word(32'h0001_00A0, 1'b1);
    expect_instr(32'h000, 32'h0000_4581, 1'b1, 1'b0);
    expect_instr(32'h002, 32'h00A0_0513, 1'b0, 1'b1);
    expect_instr(32'h006, 32'h0000_0001, 1'b1, 1'b1);
    instr_ready_i = 1'b1;
    drain("drain_err", 10);

    // Branch with concurrent push and pop
    instr_ready_i = 1'b0;
    do_branch(32'h0000_0400);
    push_word(32'h00A0_0513, 1'b0);
    check("pre_branch_valid", {31'h0, instr_valid_o}, 32'h1);
    instr_ready_i = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h9999_9993;
    do_branch(32'h0000_0500);
    fetch_valid_i = 1'b0;
    check("post_branch_valid", {31'h0, instr_valid_o}, 32'h0);
    check("post_branch_pc", instr_pc_o, 32'h500);
    check("post_branch_ready", {31'h0, fetch_ready_o}, 32'h1);
    drain("drain_branch", 4);

    // Asynchronous reset with two words buffered
    instr_ready_i = 1'b0;
    do_branch(32'h0000_0600);
    push_word(32'h1111_1113, 1'b0);
    push_word(32'h2222_2223, 1'b0);
    check("pre_rst_valid", {31'h0, instr_valid_o}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'h0, instr_valid_o}, 32'h0);
    check("async_rst_ready", {31'h0, fetch_ready_o}, 32'h1);
    check("async_rst_pc", instr_pc_o, 32'h0);
    tick();
    rst = 1'b0;
    instr_ready_i = 1'b1;
    expect_instr(32'h000, 32'h00A0_0513, 1'b0, 1'b0);
    push_word(32'h00A0_0513, 1'b0);
    drain("drain_after_rst", 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
